// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer slice:
//   - sel encodings driven by the fetch/decode logic
//   - FSM state type used by the sequencer (normal run / interrupt service)
//   - small helper for saturating decrement of the interrupt entry marker
package pc_sequencer_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_SEQ    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_BRANCH = 2'b01;
  localparam logic [SEL_W-1:0] SEL_CALL   = 2'b10;
  localparam logic [SEL_W-1:0] SEL_RET    = 2'b11;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SVC = 1'b1
  } seq_state_t;

  // Decrement by one, holding at zero (used when the oldest stack entry is
  // discarded below or at the interrupt frame).
  function automatic logic [7:0] sat_dec8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'd0) begin
      result = 8'd0;
    end else begin
      result = value - 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras
// Circular return-address stack. A push on a full stack overwrites the
// oldest entry and keeps the depth saturated; a pop on an empty stack is
// ignored (the sequencer decides what to load in that case).
// Ports:
//   clk, rst        clock, synchronous active-high reset (pointers/depth only)
//   push, pop       stack operations (push has priority; never both in use)
//   push_data       address to push
//   top_data        entry that a pop would return
//   full, empty     depth == RAS_DEPTH / depth == 0
//   depth           current number of valid entries
module pc_ras
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [ADDR_W-1:0]           push_data,
  output logic [ADDR_W-1:0]           top_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(RAS_DEPTH):0]  depth
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_r [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  top_idx_s;

  // Top-of-stack index and status decode; the pointer wraps because the
  // depth is a power of two.
  always_comb begin
    top_idx_s = wr_ptr_r - PTR_W'(1);
    top_data  = mem_r[top_idx_s];
    full      = (count_r == CNT_W'(RAS_DEPTH));
    empty     = (count_r == {CNT_W{1'b0}});
    depth     = count_r;
  end

  // Pointer and depth bookkeeping; a full-stack push advances the pointer
  // over the oldest slot so that slot is the one overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (push) begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (!full) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end else if (pop && !empty) begin
      wr_ptr_r <= wr_ptr_r - PTR_W'(1);
      count_r  <= count_r - CNT_W'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
      count_r  <= count_r;
    end
  end

  // Entry storage, intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer with return-address stack and single-level
// interrupt service FSM (RUN / SVC).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pc_enable       1 = advance PC on this edge, 0 = stall (irq still latched)
//   sel             00 seq, 01 branch, 10 call, 11 return
//   target_addr     branch/call destination
//   irq             interrupt request (pulse is enough, latched as pending)
//   pc_out          registered PC
//   irq_ack         one-cycle pulse after the edge an interrupt is taken
//   int_active      high while in interrupt service
//   ras_overflow    sticky: push onto a full stack happened
//   ras_underflow   sticky: return on an empty stack happened
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]        RESET_VEC = 32'h0000_0020,
  parameter logic [ADDR_W-1:0]        INT_VEC   = 32'h0000_0000,
  parameter int unsigned              STEP      = 32'd1,
  parameter int                       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_enable,
  input  logic [1:0]        sel,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic              irq,
  output logic [ADDR_W-1:0] pc_out,
  output logic              irq_ack,
  output logic              int_active,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int DW = $clog2(RAS_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_r;
  seq_state_t        state_r;
  logic              pending_r;
  logic              irq_ack_r;
  logic              int_active_r;
  logic              ovf_r;
  logic              udf_r;
  logic [DW-1:0]     marker_r;

  logic [ADDR_W-1:0] seq_pc_s;
  logic [ADDR_W-1:0] push_data_s;
  logic [ADDR_W-1:0] ras_top_s;
  logic [DW-1:0]     ras_depth_s;
  logic [DW-1:0]     marker_dec_s;
  logic              ras_full_s;
  logic              ras_empty_s;
  logic              take_irq_s;
  logic              push_s;
  logic              pop_s;
  logic              svc_exit_s;

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .top_data  (ras_top_s),
    .full      (ras_full_s),
    .empty     (ras_empty_s),
    .depth     (ras_depth_s)
  );

  // Next-address candidates, interrupt-take decision and stack controls.
  always_comb begin
    seq_pc_s     = pc_r + ADDR_W'(STEP);
    push_s       = 1'b0;
    pop_s        = 1'b0;
    push_data_s  = seq_pc_s;
    svc_exit_s   = 1'b0;
    marker_dec_s = DW'(sat_dec8(8'(marker_r)));

    // Interrupts are only taken in RUN and only on seq/branch edges; a
    // pending request on a call/return edge waits for the next eligible one.
    if (pc_enable && pending_r && (state_r == ST_RUN) &&
        ((sel == SEL_SEQ) || (sel == SEL_BRANCH))) begin
      take_irq_s = 1'b1;
    end else begin
      take_irq_s = 1'b0;
    end

    if (pc_enable) begin
      case (sel)
        SEL_SEQ: begin
          push_s      = take_irq_s;
          push_data_s = seq_pc_s;
        end
        SEL_BRANCH: begin
          push_s      = take_irq_s;
          push_data_s = target_addr;
        end
        SEL_CALL: begin
          push_s      = 1'b1;
          push_data_s = seq_pc_s;
        end
        SEL_RET: begin
          pop_s       = ~ras_empty_s;
          push_data_s = seq_pc_s;
        end
        default: begin
          push_s      = 1'b0;
          pop_s       = 1'b0;
          push_data_s = seq_pc_s;
        end
      endcase
    end else begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end

    // Service ends on the pop that returns the depth to the entry marker.
    if (pop_s && (state_r == ST_SVC) && ((ras_depth_s - DW'(1)) == marker_r)) begin
      svc_exit_s = 1'b1;
    end else begin
      svc_exit_s = 1'b0;
    end
  end

  // PC register, pending flag, sticky error flags and the RUN/SVC FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r         <= RESET_VEC;
      state_r      <= ST_RUN;
      pending_r    <= 1'b0;
      marker_r     <= {DW{1'b0}};
      irq_ack_r    <= 1'b0;
      int_active_r <= 1'b0;
      ovf_r        <= 1'b0;
      udf_r        <= 1'b0;
    end else begin
      // A new request on the taking edge is kept rather than lost.
      pending_r <= irq | (pending_r & ~take_irq_s);
      irq_ack_r <= take_irq_s;

      if (push_s && ras_full_s) begin
        ovf_r <= 1'b1;
      end
      if (pc_enable && (sel == SEL_RET) && ras_empty_s) begin
        udf_r <= 1'b1;
      end

      if (pc_enable) begin
        if (take_irq_s) begin
          pc_r <= INT_VEC;
        end else begin
          case (sel)
            SEL_SEQ:    pc_r <= seq_pc_s;
            SEL_BRANCH: pc_r <= target_addr;
            SEL_CALL:   pc_r <= target_addr;
            SEL_RET:    pc_r <= ras_empty_s ? seq_pc_s : ras_top_s;
            default:    pc_r <= seq_pc_s;
          endcase
        end
      end

      case (state_r)
        ST_RUN: begin
          if (take_irq_s) begin
            state_r      <= ST_SVC;
            int_active_r <= 1'b1;
            // On a full stack the frame push discards the oldest entry, so
            // one fewer entry sits underneath the frame.
            marker_r     <= ras_full_s ? DW'(RAS_DEPTH - 1) : ras_depth_s;
          end
        end
        ST_SVC: begin
          if (svc_exit_s) begin
            state_r      <= ST_RUN;
            int_active_r <= 1'b0;
          end else if (push_s && ras_full_s) begin
            // Oldest entry dropped: the frame moves one slot down, or is
            // lost entirely once the marker is already zero.
            marker_r <= marker_dec_s;
          end
        end
        default: begin
          state_r      <= ST_RUN;
          int_active_r <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out        = pc_r;
  assign irq_ack       = irq_ack_r;
  assign int_active    = int_active_r;
  assign ras_overflow  = ovf_r;
  assign ras_underflow = udf_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Scoreboard bench: the driver applies stimulus on the falling edge, runs a
// queue-based reference model and pushes the expected post-edge outputs; a
// monitor pops and compares one entry shortly after every rising edge.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_enable = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] target_addr = 32'h0;
  logic        irq = 1'b0;
  logic [31:0] pc_out;
  logic        irq_ack;
  logic        int_active;
  logic        ras_overflow;
  logic        ras_underflow;

  pc_sequencer #(
    .ADDR_W    (32),
    .RESET_VEC (32'h20),
    .INT_VEC   (32'h0),
    .STEP      (1),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_enable     (pc_enable),
    .sel           (sel),
    .target_addr   (target_addr),
    .irq           (irq),
    .pc_out        (pc_out),
    .irq_ack       (irq_ack),
    .int_active    (int_active),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ack;
    logic        act;
    logic        ovf;
    logic        udf;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          frame;
  } ent_t;

  exp_t exp_q[$];
  exp_t mon_e;
  ent_t stk[$];

  logic [31:0] m_pc;
  bit m_svc, m_pend, m_ack, m_ovf, m_udf, m_lost;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // Reference model: stack as a list of entries, the interrupt frame tagged.
  task automatic m_push(input logic [31:0] a, input bit fr);
    ent_t old;
    if (stk.size() == 4) begin
      old = stk.pop_front();
      if (old.frame) m_lost = 1'b1;
      m_ovf = 1'b1;
    end
    stk.push_back('{addr: a, frame: fr});
  endtask

  task automatic model_step(input bit r, input bit en, input logic [1:0] s,
                            input logic [31:0] t, input bit i);
    bit take;
    ent_t e;
    if (r) begin
      m_pc = 32'h20; m_svc = 0; m_pend = 0; m_ack = 0;
      m_ovf = 0; m_udf = 0; m_lost = 0;
      stk.delete();
    end else begin
      take  = m_pend && en && !m_svc && (s == SEL_SEQ || s == SEL_BRANCH);
      m_ack = take;
      if (en) begin
        if (take) begin
          m_push((s == SEL_SEQ) ? m_pc + 32'd1 : t, 1'b1);
          m_pc = 32'h0; m_svc = 1'b1; m_lost = 1'b0;
        end else if (s == SEL_SEQ) begin
          m_pc = m_pc + 32'd1;
        end else if (s == SEL_BRANCH) begin
          m_pc = t;
        end else if (s == SEL_CALL) begin
          m_push(m_pc + 32'd1, 1'b0);
          m_pc = t;
        end else if (stk.size() == 0) begin
          m_pc = m_pc + 32'd1;
          m_udf = 1'b1;
        end else begin
          e = stk.pop_back();
          m_pc = e.addr;
          if (m_svc && (e.frame || (m_lost && stk.size() == 0))) m_svc = 1'b0;
        end
      end
      m_pend = i || (m_pend && !take);
    end
  endtask

  task automatic drive(input bit r, input bit en, input logic [1:0] s,
                       input logic [31:0] t, input bit i);
    @(negedge clk);
    rst = r; pc_enable = en; sel = s; target_addr = t; irq = i;
    model_step(r, en, s, t, i);
    exp_q.push_back('{pc: m_pc, ack: m_ack, act: m_svc, ovf: m_ovf, udf: m_udf});
  endtask

  // Monitor: one expected entry per clock, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pc_out",        pc_out,                mon_e.pc);
      check("irq_ack",       {31'd0, irq_ack},       {31'd0, mon_e.ack});
      check("int_active",    {31'd0, int_active},    {31'd0, mon_e.act});
      check("ras_overflow",  {31'd0, ras_overflow},  {31'd0, mon_e.ovf});
      check("ras_underflow", {31'd0, ras_underflow}, {31'd0, mon_e.udf});
    end
  end

  initial begin
    logic        r_b, e_b, i_b;
    logic [1:0]  s_v;
    logic [31:0] t_v;

    // Reset and sequential run: 0x20 -> 0x23
    drive(1, 0, SEL_SEQ, 32'h0, 0);
    repeat (3) drive(0, 1, SEL_SEQ, 32'h0, 0);
    // Call / sequential / return
    drive(0, 1, SEL_CALL, 32'h100, 0);
    repeat (2) drive(0, 1, SEL_SEQ, 32'h0, 0);
    drive(0, 1, SEL_RET, 32'h0, 0);
    // irq latched while stalled, taken at pc=0x30, service, return to 0x31
    drive(0, 1, SEL_BRANCH, 32'h30, 0);
    drive(0, 0, SEL_SEQ, 32'h0, 1);
    repeat (2) drive(0, 0, SEL_SEQ, 32'h0, 0);
    drive(0, 1, SEL_SEQ, 32'h0, 0);
    repeat (2) drive(0, 1, SEL_SEQ, 32'h0, 0);
    drive(0, 1, SEL_RET, 32'h0, 0);
    // Pending irq deferred by a call, taken on the next seq edge
    drive(0, 0, SEL_SEQ, 32'h0, 1);
    drive(0, 1, SEL_CALL, 32'h200, 0);
    drive(0, 1, SEL_SEQ, 32'h0, 0);
    drive(0, 1, SEL_CALL, 32'h300, 0);
    drive(0, 1, SEL_RET, 32'h0, 0);
    repeat (3) drive(0, 1, SEL_RET, 32'h0, 0);
    // Overflow / underflow: 5 calls then 5 returns from a clean reset
    drive(1, 0, SEL_SEQ, 32'h0, 0);
    for (int k = 0; k < 5; k++) drive(0, 1, SEL_CALL, 32'h1000 + 32'(k) * 32'h10, 0);
    for (int k = 0; k < 5; k++) drive(0, 1, SEL_RET, 32'h0, 0);
    // Reset during service with a new pending irq
    drive(1, 0, SEL_SEQ, 32'h0, 0);
    drive(0, 0, SEL_SEQ, 32'h0, 1);
    drive(0, 1, SEL_SEQ, 32'h0, 0);
    drive(0, 1, SEL_SEQ, 32'h0, 1);
    drive(1, 1, SEL_SEQ, 32'h0, 0);
    repeat (4) drive(0, 1, SEL_SEQ, 32'h0, 0);
    // Wrap-around of pc+STEP
    drive(0, 1, SEL_BRANCH, 32'hFFFF_FFFF, 0);
    drive(0, 1, SEL_SEQ, 32'h0, 0);
    drive(0, 1, SEL_CALL, 32'hFFFF_FFFF, 0);
    drive(0, 1, SEL_CALL, 32'h40, 0);
    drive(0, 1, SEL_RET, 32'h0, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r_b = ($urandom_range(0, 299) == 0);
      e_b = ($urandom_range(0, 9) < 8);
      s_v = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       t_v = $urandom;
        1:       t_v = 32'hFFFF_FFFF;
        default: t_v = 32'($urandom_range(0, 255));
      endcase
      i_b = ($urandom_range(0, 7) == 0);
      drive(r_b, e_b, s_v, t_v, i_b);
    end

    drive(0, 0, SEL_SEQ, 32'h0, 0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
